// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite controller.
// The optional horizontal mirror is enabled by defining SPRITE_HFLIP_EN.
package sprite_pkg;

    localparam int unsigned SPR_SIZE   = 16;
    localparam int unsigned SPR_BITS   = 4;
    localparam int unsigned OPAQUE_BIT = 24;

    // Layout of RAM word 0; reserved bits are stored but never used.
    typedef struct packed {
        logic       enable;    // [31]
        logic       hflip;     // [30]
        logic [3:0] rsvd_hi;   // [29:26]
        logic [9:0] y;         // [25:16]
        logic [5:0] rsvd_lo;   // [15:10]
        logic [9:0] x;         // [9:0]
    } sprite_ctrl_t;

endpackage

// File: rtl/sprite_hit_detect.sv
// Combinational sprite box test and in-sprite coordinates.
// Defining SPRITE_HFLIP_EN makes hflip mirror rel_x; otherwise hflip is ignored.
module sprite_hit_detect
    import sprite_pkg::*;
#(
    parameter int unsigned XW = 10
) (
    input  logic          pix_valid,
    input  logic [XW-1:0] pix_x,
    input  logic [XW-1:0] pix_y,
    input  logic [XW-1:0] spr_x,
    input  logic [XW-1:0] spr_y,
    input  logic          enable,
    input  logic          hflip,
    output logic          in_sprite,
    output logic [3:0]    rel_x,
    output logic [3:0]    rel_y
);

    logic [XW:0] dx;
    logic [XW:0] dy;
    logic [3:0]  col;

    // One extra bit so a pixel left of/above the sprite borrows and lands out of range.
    assign dx = {1'b0, pix_x} - {1'b0, spr_x};
    assign dy = {1'b0, pix_y} - {1'b0, spr_y};

    assign in_sprite = pix_valid & enable
                     & (dx[XW:SPR_BITS] == '0)
                     & (dy[XW:SPR_BITS] == '0);

`ifdef SPRITE_HFLIP_EN
    assign col = hflip ? (4'(SPR_SIZE - 1) - dx[3:0]) : dx[3:0];
`else
    logic unused_hflip;
    assign unused_hflip = hflip;
    assign col = dx[3:0];
`endif

    assign rel_x = in_sprite ? col : 4'd0;
    assign rel_y = in_sprite ? dy[3:0] : 4'd0;

endmodule

// File: rtl/sprite_ctrl.sv
// Sprite overlay: per-frame shadowed control word, 1-cycle composite, per-frame collision.
// Optional horizontal mirror via SPRITE_HFLIP_EN (handled in sprite_hit_detect).
module sprite_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned XW       = 10,
    parameter logic [23:0] WALL_RGB = 24'h0000FF
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [XW-1:0] pix_x,
    input  logic [XW-1:0] pix_y,
    input  logic [23:0]   bg_rgb,
    input  logic [31:0]   sprite_data,
    input  logic [31:0]   sprite_pixel,
    output logic          in_sprite,
    output logic [3:0]    rel_x,
    output logic [3:0]    rel_y,
    output logic          out_valid,
    output logic [23:0]   out_rgb,
    output logic          collision
);

    sprite_ctrl_t shadow_q;
    logic         acc_q;
    logic         opaque;
    logic         hit;

    sprite_hit_detect #(
        .XW (XW)
    ) u_hit (
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .spr_x     (XW'(shadow_q.x)),
        .spr_y     (XW'(shadow_q.y)),
        .enable    (shadow_q.enable),
        .hflip     (shadow_q.hflip),
        .in_sprite (in_sprite),
        .rel_x     (rel_x),
        .rel_y     (rel_y)
    );

    assign opaque = sprite_pixel[OPAQUE_BIT];
    assign hit    = in_sprite & opaque & (bg_rgb == WALL_RGB);

    logic unused_bits;
    assign unused_bits = ^{sprite_pixel[31:25], shadow_q.rsvd_hi, shadow_q.rsvd_lo};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            shadow_q  <= '0;
            acc_q     <= 1'b0;
            collision <= 1'b0;
            out_valid <= 1'b0;
            out_rgb   <= 24'h0;
        end else begin
            // The pixel coinciding with frame_start still uses the old shadow and
            // its hit lands in the value published now.
            if (frame_start) begin
                shadow_q  <= sprite_ctrl_t'(sprite_data);
                collision <= acc_q | hit;
                acc_q     <= 1'b0;
            end else begin
                acc_q <= acc_q | hit;
            end
            out_valid <= pix_valid;
            if (!pix_valid) begin
                out_rgb <= 24'h0;
            end else if (in_sprite && opaque) begin
                out_rgb <= sprite_pixel[23:0];
            end else begin
                out_rgb <= bg_rgb;
            end
        end
    end

endmodule

// File: tb/tb_sprite_ctrl.sv
// Directed self-checking bench for sprite_ctrl; honours SPRITE_HFLIP_EN for the flip check.
module tb_sprite_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] bg_rgb;
    logic [31:0] sprite_data;
    logic [31:0] sprite_pixel;
    logic        in_sprite;
    logic [3:0]  rel_x;
    logic [3:0]  rel_y;
    logic        out_valid;
    logic [23:0] out_rgb;
    logic        collision;

    int total  = 0;
    int passes = 0;

    sprite_ctrl #(
        .XW       (10),
        .WALL_RGB (24'h0000FF)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .bg_rgb       (bg_rgb),
        .sprite_data  (sprite_data),
        .sprite_pixel (sprite_pixel),
        .in_sprite    (in_sprite),
        .rel_x        (rel_x),
        .rel_y        (rel_y),
        .out_valid    (out_valid),
        .out_rgb      (out_rgb),
        .collision    (collision)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] mk(input logic en, input logic flip,
                                       input int unsigned x, input int unsigned y);
        logic [9:0] xb;
        logic [9:0] yb;
        xb = 10'(x);
        yb = 10'(y);
        return {en, flip, 4'b0, yb, 6'b0, xb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic fs, input logic pv, input int unsigned x,
                         input int unsigned y, input logic [23:0] bg, input logic [31:0] sp);
        frame_start  = fs;
        pix_valid    = pv;
        pix_x        = 10'(x);
        pix_y        = 10'(y);
        bg_rgb       = bg;
        sprite_pixel = sp;
        #1;
    endtask

    localparam logic [31:0] OPQ_YEL  = 32'h01FFFF00;
    localparam logic [31:0] TRANSP   = 32'h00ABCDEF;
    localparam logic [23:0] WALL     = 24'h0000FF;

    logic [3:0] flip_exp;

    initial begin
        HRESET = 1'b1;
        sprite_data = 32'h0;
        drive(0, 0, 0, 0, 24'h0, 32'h0);
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_rgb", 32'(out_rgb), 0);
        chk("rst_collision", 32'(collision), 0);
        chk("rst_in_sprite", 32'(in_sprite), 0);
        HRESET = 1'b0;

        // Control word not yet latched: sprite stays hidden.
        sprite_data = mk(1, 0, 200, 100);
        drive(0, 1, 205, 103, 24'h123456, OPQ_YEL);
        chk("pre_latch_in", 32'(in_sprite), 0);
        tick();
        chk("pre_latch_rgb", 32'(out_rgb), 32'h123456);
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();

        // Placement and opaque composite
        drive(0, 1, 205, 103, 24'h123456, OPQ_YEL);
        chk("place_in", 32'(in_sprite), 1);
        chk("place_rel_x", 32'(rel_x), 5);
        chk("place_rel_y", 32'(rel_y), 3);
        tick();
        chk("opaque_valid", 32'(out_valid), 1);
        chk("opaque_rgb", 32'(out_rgb), 32'hFFFF00);
        drive(0, 1, 206, 103, 24'h112233, TRANSP);
        chk("transp_in", 32'(in_sprite), 1);
        tick();
        chk("transp_rgb", 32'(out_rgb), 32'h112233);
        drive(0, 1, 199, 103, 24'h0, OPQ_YEL);
        chk("left_out", 32'(in_sprite), 0);
        chk("left_relx", 32'(rel_x), 0);
        tick();
        chk("left_rgb_bg", 32'(out_rgb), 0);
        drive(0, 1, 216, 103, 24'h0, OPQ_YEL);
        chk("right_out", 32'(in_sprite), 0);
        drive(0, 1, 215, 115, 24'h0, OPQ_YEL);
        chk("corner_in", 32'(in_sprite), 1);
        chk("corner_rel_x", 32'(rel_x), 15);
        chk("corner_rel_y", 32'(rel_y), 15);
        drive(0, 1, 205, 116, 24'h0, OPQ_YEL);
        chk("below_out", 32'(in_sprite), 0);
        drive(0, 0, 205, 103, 24'h123456, OPQ_YEL);
        chk("invalid_in", 32'(in_sprite), 0);
        tick();
        chk("invalid_valid", 32'(out_valid), 0);
        chk("invalid_rgb", 32'(out_rgb), 0);

        // Mid-frame write must not move the sprite
        sprite_data = mk(1, 0, 300, 100);
        drive(0, 1, 205, 103, 24'h0, 32'h0);
        chk("shadow_old_in", 32'(in_sprite), 1);
        drive(0, 1, 305, 103, 24'h0, 32'h0);
        chk("shadow_new_out", 32'(in_sprite), 0);

        // Collision in this frame, published at next frame_start
        drive(0, 1, 205, 103, WALL, OPQ_YEL);
        tick();
        drive(0, 0, 0, 0, 24'h0, 32'h0);
        chk("coll_before_fs", 32'(collision), 0);
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();
        chk("coll_set", 32'(collision), 1);
        drive(0, 1, 305, 103, 24'h123456, OPQ_YEL);
        chk("shadow_new_in", 32'(in_sprite), 1);
        chk("shadow_new_relx", 32'(rel_x), 5);
        tick();
        chk("coll_hold", 32'(collision), 1);
        drive(0, 1, 205, 103, WALL, OPQ_YEL);
        chk("shadow_old_out", 32'(in_sprite), 0);
        tick();
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();
        chk("coll_clear", 32'(collision), 0);

        // frame_start with a pixel: old shadow, hit folded into published value
        sprite_data = mk(1, 0, 630, 100);
        drive(1, 1, 305, 103, WALL, OPQ_YEL);
        chk("fs_old_shadow", 32'(in_sprite), 1);
        tick();
        chk("fs_coll_fold", 32'(collision), 1);
        drive(0, 1, 639, 103, 24'h0, 32'h0);
        chk("edge_in", 32'(in_sprite), 1);
        chk("edge_rel_x", 32'(rel_x), 9);
        drive(0, 1, 0, 103, 24'h0, 32'h0);
        chk("edge_nowrap", 32'(in_sprite), 0);
        drive(0, 1, 629, 103, WALL, OPQ_YEL);
        chk("edge_left_out", 32'(in_sprite), 0);
        tick();
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();
        chk("fold_acc_cleared", 32'(collision), 0);

        // Flip bit: mirrored only when the feature is built in
        sprite_data = mk(1, 1, 200, 100);
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();
`ifdef SPRITE_HFLIP_EN
        flip_exp = 4'd10;
`else
        flip_exp = 4'd5;
`endif
        drive(0, 1, 205, 103, WALL, OPQ_YEL);
        chk("flip_rel_x", 32'(rel_x), 32'(flip_exp));
        chk("flip_rel_y", 32'(rel_y), 3);
        tick();
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();
        chk("coll_before_rst", 32'(collision), 1);

        // Asynchronous reset mid-frame
        drive(0, 1, 205, 103, WALL, OPQ_YEL);
        tick();
        HRESET = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_rgb", 32'(out_rgb), 0);
        chk("mid_rst_coll", 32'(collision), 0);
        chk("mid_rst_in", 32'(in_sprite), 0);
        tick();
        HRESET = 1'b0;
        drive(0, 1, 205, 103, WALL, OPQ_YEL);
        chk("post_rst_hidden", 32'(in_sprite), 0);
        tick();
        chk("post_rst_rgb_bg", 32'(out_rgb), 32'(WALL));
        drive(1, 0, 0, 0, 24'h0, 32'h0);
        tick();
        chk("post_rst_no_coll", 32'(collision), 0);
        drive(0, 1, 205, 103, 24'h0, 32'h0);
        chk("post_rst_visible", 32'(in_sprite), 1);
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/sprite_ctrl.md
Name: sprite_ctrl

Overview:
- Sprite controller in front of the sprite RAM; consumes the VGA pixel stream and overlays a 16x16 sprite onto the background.
- Samples the sprite control word once per frame.
- Drives in_sprite/rel_x/rel_y to the RAM and takes sprite_pixel back in the same cycle.
- Emits a one-cycle-delayed composited RGB stream plus a per-frame sprite/wall collision flag for software.

Parameters:
- XW, 10, pixel x/y coordinate width
- WALL_RGB, 24'h0000FF, background colour counted as a wall for collision
- SPR_SIZE, 16, sprite edge in pixels (fixed; rel_x/rel_y are 4 bits)

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each frame
- pix_valid  in  1  current pixel is in the visible area
- pix_x  in  XW  current pixel column
- pix_y  in  XW  current pixel row
- bg_rgb  in  24  background colour for the current pixel
- sprite_data  in  32  RAM word 0, the control word: [9:0] x, [25:16] y, [31] enable, [30] hflip
- sprite_pixel  in  32  RAM pixel for (rel_x, rel_y): [23:0] RGB, [24] opaque
- in_sprite  out  1  current pixel lies inside the sprite box
- rel_x  out  4  column within the sprite
- rel_y  out  4  row within the sprite
- out_valid  out  1  pix_valid delayed by 1 cycle
- out_rgb  out  24  composited colour
- collision  out  1  collision result for the previous frame

Behaviour:
- Clock/reset: single clock HCLK; HRESET is asynchronous and active-high.
- Reset values: shadow control register = 0 (sprite disabled); out_valid=0; out_rgb=0; collision=0; collision accumulator=0.
  - in_sprite, rel_x and rel_y are combinational and therefore read 0 while the shadow is disabled.
- Shadow latch:
  - On frame_start the shadow register loads sprite_data.
  - sprite_data is ignored at all other times, so a mid-frame write never tears the sprite.
- Hit compute, combinational from pix_x, pix_y and the shadow:
  - dx = pix_x - sx and dy = pix_y - sy, computed at XW+1 bits, unsigned.
  - in_sprite = pix_valid & enable & (dx < 16) & (dy < 16); the borrow bit set means outside.
  - rel_x = dx[3:0] and rel_y = dy[3:0] when in_sprite, else 0.
  - A sprite near the right or bottom edge clips. No wrap-around: sx=630 covers columns 630..639 and beyond only if those columns are visible.
- Composite stage, registered, latency 1:
  - out_valid <= pix_valid.
  - out_rgb <= (in_sprite & sprite_pixel[24]) ? sprite_pixel[23:0] : bg_rgb.
  - out_rgb <= 0 when pix_valid=0.
- Collision:
  - hit = in_sprite & sprite_pixel[24] & (bg_rgb == WALL_RGB).
  - The accumulator is sticky-ORed with hit every cycle.
  - On frame_start: collision <= acc | hit, and acc <= 0.
  - collision holds its value for the whole following frame.
- Simultaneous frame_start and pix_valid:
  - That pixel is evaluated with the OLD shadow.
  - Its hit is folded into the collision value published that cycle.
- Reset mid-frame: all state clears immediately. The sprite stays hidden until the next frame_start.
- No backpressure: one pixel per cycle whenever pix_valid=1.

Optional Feature:
- Macro: SPRITE_HFLIP_EN.
- Defined: when shadow[30]=1, rel_x = 15 - dx[3:0] (horizontal mirror); rel_y is unaffected.
- Undefined: bit 30 is ignored and rel_x = dx[3:0] always.

Decomposition:
- Package sprite_pkg holds:
  - the sprite_ctrl_t packed struct for the control word (x, y, enable, hflip bit positions);
  - OPAQUE_BIT = 24;
  - SPR_SIZE.
- Sub-module sprite_hit_detect contains the combinational range compare plus rel_x/rel_y (including the flip).
- sprite_ctrl contains the shadow register, the composite pipeline and the collision logic.

Test Plan:
- Reset behaviour: assert HRESET mid-stream -> out_valid=0, out_rgb=0, collision=0, and in_sprite=0 until the next frame_start even with enable set in sprite_data.
- Placement: sprite_data = {enable=1, y=100, x=200}, then frame_start, pixel (205,103) -> in_sprite=1, rel_x=5, rel_y=3; pixels (199,103) and (216,103) -> in_sprite=0.
- Transparency: opaque pixel RGB 24'hFFFF00 -> out_rgb=FFFF00 one cycle later; sprite_pixel[24]=0 -> out_rgb=bg_rgb.
- Shadowing: change sprite_data x to 300 mid-frame -> in_sprite still follows x=200 until the next frame_start, then follows x=300.
- Collision: one opaque sprite pixel over bg_rgb=0000FF in frame N -> collision=1 after frame N+1's frame_start; no hit in frame N+1 -> collision=0 after frame N+2's frame_start.
- Edge clipping and flip: x=630 -> pixel 639 gives rel_x=9 and no wrap to column 0; with SPRITE_HFLIP_EN and hflip=1, pixel (205,103) -> rel_x=10.
